// File: rtl/dpram_pkg.sv
// Shared widths, arbitration limits and owner encoding for the dual-requester RAM port arbiter.
package dpram_pkg;

  localparam int ADDR_W_DEF   = 9;
  localparam int DATA_W_DEF   = 16;
  localparam int SEL_W_DEF    = 2;
  localparam int MAX_HOLD_DEF = 4;
  localparam int HOLD_W       = 4;

  typedef enum logic [0:0] {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN0) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/dpram_port_arb_if.sv
// Requester and RAM-side signal bundle for dpram_port_arb; slave is the arbiter view,
// master is the view of whatever drives the requests and models the RAM.
interface dpram_port_arb_if
  import dpram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) ();

  logic              m0_req;
  logic              m0_lock;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [SEL_W-1:0]  m0_sel;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_lock;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [SEL_W-1:0]  m1_sel;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [SEL_W-1:0]  ram_sel;
  logic              ram_we;
  logic              ram_ce;
  logic [DATA_W-1:0] ram_write;
  logic [DATA_W-1:0] ram_read;

  modport slave (
    input  m0_req, m0_lock, m0_we, m0_addr, m0_sel, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_lock, m1_we, m1_addr, m1_sel, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_addr, ram_sel, ram_we, ram_ce, ram_write,
    input  ram_read
  );

  modport master (
    output m0_req, m0_lock, m0_we, m0_addr, m0_sel, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_lock, m1_we, m1_addr, m1_sel, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_addr, ram_sel, ram_we, ram_ce, ram_write,
    output ram_read
  );

endinterface

// File: rtl/dpram_rr_sched.sv
// Owner/hold scheduler: combinational grants plus the owner register. Lock/hold streaks are
// compiled in only with DPRAM_PORT_ARB_LOCK_EN; otherwise ownership flips after every grant.
module dpram_rr_sched
  import dpram_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic lock0,
  input  logic lock1,
  output logic gnt0,
  output logic gnt1
);

  owner_t owner_r;
  logic   gnt0_s;
  logic   gnt1_s;
  owner_t gsel_s;

  // A lone requester wins outright; the owner only breaks ties.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0 && (!req1 || owner_r == OWN0)) begin
      gnt0_s = 1'b1;
    end else if (req1) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign gsel_s = gnt1_s ? OWN1 : OWN0;
  assign gnt0   = gnt0_s;
  assign gnt1   = gnt1_s;

`ifdef DPRAM_PORT_ARB_LOCK_EN
  localparam logic [HOLD_W-1:0] MAX_HOLD_L = HOLD_W'(MAX_HOLD);

  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] run_s;
  logic              lock_s;
  logic              stay_s;

  // run_s counts the granted requester's streak including this grant.
  always_comb begin
    lock_s = gnt1_s ? lock1 : lock0;
    if (gsel_s == owner_r) begin
      run_s = hold_r + 4'd1;
    end else begin
      run_s = 4'd1;
    end
    stay_s = lock_s && (run_s < MAX_HOLD_L);
  end

  // Owner/hold update after each granted cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r <= OWN0;
      hold_r  <= 4'd0;
    end else if (gnt0_s || gnt1_s) begin
      if (stay_s) begin
        owner_r <= gsel_s;
        hold_r  <= run_s;
      end else begin
        owner_r <= other_owner(gsel_s);
        hold_r  <= 4'd0;
      end
    end
  end
`else
  logic unused_cfg_s;
  assign unused_cfg_s = lock0 | lock1 | (MAX_HOLD == 0);

  // Pure round-robin: ownership passes to the other requester after every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r <= OWN0;
    end else if (gnt0_s || gnt1_s) begin
      owner_r <= other_owner(gsel_s);
    end
  end
`endif

endmodule

// File: rtl/dpram_port_arb.sv
// Two-requester arbiter for a single synchronous RAM port (1-cycle read latency).
// Optional lock/hold ownership is enabled by defining DPRAM_PORT_ARB_LOCK_EN.
module dpram_port_arb
  import dpram_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  dpram_port_arb_if.slave     bus
);

  logic              gnt0_s;
  logic              gnt1_s;
  logic              rvalid0_r;
  logic              rvalid1_r;
  logic [ADDR_W-1:0] addr_s;
  logic [SEL_W-1:0]  sel_s;
  logic              we_s;
  logic [DATA_W-1:0] wdata_s;

  dpram_rr_sched #(
    .MAX_HOLD (MAX_HOLD)
  ) u_sched (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (bus.m0_req),
    .req1  (bus.m1_req),
    .lock0 (bus.m0_lock),
    .lock1 (bus.m1_lock),
    .gnt0  (gnt0_s),
    .gnt1  (gnt1_s)
  );

  // Steer the winner's access onto the RAM port; idle keeps we and lanes off.
  always_comb begin
    addr_s  = '0;
    sel_s   = '0;
    we_s    = 1'b0;
    wdata_s = '0;
    if (gnt0_s) begin
      addr_s  = bus.m0_addr;
      sel_s   = bus.m0_sel;
      we_s    = bus.m0_we;
      wdata_s = bus.m0_wdata;
    end else if (gnt1_s) begin
      addr_s  = bus.m1_addr;
      sel_s   = bus.m1_sel;
      we_s    = bus.m1_we;
      wdata_s = bus.m1_wdata;
    end else begin
      addr_s  = '0;
      sel_s   = '0;
      we_s    = 1'b0;
      wdata_s = '0;
    end
  end

  assign bus.ram_addr  = addr_s;
  assign bus.ram_sel   = sel_s;
  assign bus.ram_we    = we_s;
  assign bus.ram_write = wdata_s;
  assign bus.ram_ce    = rst_n & (bus.m0_req | bus.m1_req);

  // Read-data valid follows a granted read by exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
    end else begin
      rvalid0_r <= gnt0_s & ~bus.m0_we;
      rvalid1_r <= gnt1_s & ~bus.m1_we;
    end
  end

  assign bus.m0_gnt    = gnt0_s;
  assign bus.m1_gnt    = gnt1_s;
  assign bus.m0_rvalid = rvalid0_r;
  assign bus.m1_rvalid = rvalid1_r;
  assign bus.m0_rdata  = bus.ram_read;
  assign bus.m1_rdata  = bus.ram_read;

endmodule

// File: tb/tb_dpram_port_arb.sv
// Randomised bench for dpram_port_arb with a behavioural RAM and arbitration model.
module tb_dpram_port_arb;
  import dpram_pkg::*;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int SW = 2;
  localparam int MH = 4;
  localparam int DEPTH = 1 << AW;
`ifdef DPRAM_PORT_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dpram_port_arb_if #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) bus ();

  dpram_port_arb #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM seen by the DUT: synchronous read, byte-masked write
  logic [DW-1:0] ram_mem [0:DEPTH-1];
  logic [DW-1:0] ram_q = '0;
  assign bus.ram_read = ram_q;

  always @(posedge clk) begin
    if (bus.ram_ce) begin
      if (bus.ram_we) begin
        for (int b = 0; b < SW; b++)
          if (bus.ram_sel[b]) ram_mem[bus.ram_addr][8*b +: 8] <= bus.ram_write[8*b +: 8];
      end else begin
        ram_q <= ram_mem[bus.ram_addr];
      end
    end
  end

  // Reference model state
  logic [DW-1:0] exp_mem [0:DEPTH-1];
  int            own = 0;
  int            streak = 0;
  bit            pend [2];
  logic [DW-1:0] pend_data [2];

  always @(negedge clk) begin
    int            g;
    int            prior;
    logic [AW-1:0] a;
    logic [SW-1:0] s;
    logic          w;
    logic          lk;
    logic [DW-1:0] d;
    if (!rst_n) begin
      chk("rst_gnt0", {31'd0, bus.m0_gnt}, 32'd0);
      chk("rst_gnt1", {31'd0, bus.m1_gnt}, 32'd0);
      chk("rst_ce", {31'd0, bus.ram_ce}, 32'd0);
      chk("rst_we", {31'd0, bus.ram_we}, 32'd0);
      chk("rst_rvalid0", {31'd0, bus.m0_rvalid}, 32'd0);
      chk("rst_rvalid1", {31'd0, bus.m1_rvalid}, 32'd0);
      own = 0;
      streak = 0;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
    end else begin
      g = -1;
      if (bus.m0_req && bus.m1_req) g = own;
      else if (bus.m0_req) g = 0;
      else if (bus.m1_req) g = 1;
      chk("gnt0", {31'd0, bus.m0_gnt}, (g == 0) ? 32'd1 : 32'd0);
      chk("gnt1", {31'd0, bus.m1_gnt}, (g == 1) ? 32'd1 : 32'd0);
      chk("ram_ce", {31'd0, bus.ram_ce}, (g >= 0) ? 32'd1 : 32'd0);
      chk("rvalid0", {31'd0, bus.m0_rvalid}, {31'd0, pend[0]});
      chk("rvalid1", {31'd0, bus.m1_rvalid}, {31'd0, pend[1]});
      if (pend[0]) chk("rdata0", {16'd0, bus.m0_rdata}, {16'd0, pend_data[0]});
      if (pend[1]) chk("rdata1", {16'd0, bus.m1_rdata}, {16'd0, pend_data[1]});
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      if (g >= 0) begin
        if (g == 0) begin
          a = bus.m0_addr; s = bus.m0_sel; w = bus.m0_we; d = bus.m0_wdata; lk = bus.m0_lock;
        end else begin
          a = bus.m1_addr; s = bus.m1_sel; w = bus.m1_we; d = bus.m1_wdata; lk = bus.m1_lock;
        end
        chk("ram_addr", {23'd0, bus.ram_addr}, {23'd0, a});
        chk("ram_sel", {30'd0, bus.ram_sel}, {30'd0, s});
        chk("ram_we", {31'd0, bus.ram_we}, {31'd0, w});
        chk("ram_write", {16'd0, bus.ram_write}, {16'd0, d});
        if (w) begin
          for (int b = 0; b < SW; b++)
            if (s[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
        end else begin
          pend[g] = 1'b1;
          pend_data[g] = exp_mem[a];
        end
        // a locked requester may take at most MH grants in a row
        prior = (g == own) ? streak : 0;
        if (LOCK_EN && lk && (prior + 1 < MH)) begin
          own = g;
          streak = prior + 1;
        end else begin
          own = 1 - g;
          streak = 0;
        end
      end else begin
        chk("idle_we", {31'd0, bus.ram_we}, 32'd0);
        chk("idle_sel", {30'd0, bus.ram_sel}, 32'd0);
      end
    end
  end

  task automatic set_m(input int n, input bit req, input bit lock, input bit we,
                       input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [DW-1:0] d);
    if (n == 0) begin
      bus.m0_req = req; bus.m0_lock = lock; bus.m0_we = we;
      bus.m0_addr = a; bus.m0_sel = s; bus.m0_wdata = d;
    end else begin
      bus.m1_req = req; bus.m1_lock = lock; bus.m1_we = we;
      bus.m1_addr = a; bus.m1_sel = s; bus.m1_wdata = d;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_both();
    set_m(0, 1'b0, 1'b0, 1'b0, 9'h000, 2'b00, 16'h0000);
    set_m(1, 1'b0, 1'b0, 1'b0, 9'h000, 2'b00, 16'h0000);
  endtask

  int pat [6];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = 16'h0000;
      exp_mem[i] = 16'h0000;
    end
    idle_both();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ce", {31'd0, bus.ram_ce}, 32'd0);

    // lone m1 write right after reset
    next_cycle();
    rst_n = 1'b1;
    set_m(1, 1'b1, 1'b0, 1'b1, 9'h010, 2'b11, 16'hBEEF);
    @(negedge clk);
    chk("w1_m1_gnt", {31'd0, bus.m1_gnt}, 32'd1);
    chk("w1_m0_gnt", {31'd0, bus.m0_gnt}, 32'd0);
    chk("w1_ram_we", {31'd0, bus.ram_we}, 32'd1);
    next_cycle();
    idle_both();
    @(negedge clk);
    chk("w1_no_rvalid", {31'd0, bus.m1_rvalid}, 32'd0);

    // contended reads: owner m0 first, then m1
    next_cycle();
    set_m(0, 1'b1, 1'b0, 1'b0, 9'h010, 2'b11, 16'h0000);
    set_m(1, 1'b1, 1'b0, 1'b0, 9'h011, 2'b11, 16'h0000);
    @(negedge clk);
    chk("rd_m0_first", {31'd0, bus.m0_gnt}, 32'd1);
    chk("rd_m1_wait", {31'd0, bus.m1_gnt}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rd_m1_next", {31'd0, bus.m1_gnt}, 32'd1);
    chk("rd_m0_rvalid", {31'd0, bus.m0_rvalid}, 32'd1);
    chk("rd_m0_rdata", {16'd0, bus.m0_rdata}, 32'h0000BEEF);

    // byte-lane write then read back
    next_cycle();
    idle_both();
    set_m(0, 1'b1, 1'b0, 1'b1, 9'h010, 2'b01, 16'h1234);
    next_cycle();
    set_m(0, 1'b1, 1'b0, 1'b0, 9'h010, 2'b11, 16'h0000);
    next_cycle();
    idle_both();
    @(negedge clk);
    chk("bw_rvalid", {31'd0, bus.m0_rvalid}, 32'd1);
    chk("bw_rdata", {16'd0, bus.m0_rdata}, 32'h0000BE34);

    // lone m1 grant hands ownership back to m0, then sustained contention with m0 locked
    next_cycle();
    set_m(1, 1'b1, 1'b0, 1'b0, 9'h005, 2'b11, 16'h0000);
    next_cycle();
    set_m(0, 1'b1, 1'b1, 1'b0, 9'h001, 2'b11, 16'h0000);
    set_m(1, 1'b1, 1'b0, 1'b0, 9'h002, 2'b11, 16'h0000);
    if (LOCK_EN) pat = '{0, 0, 0, 0, 1, 0};
    else pat = '{0, 1, 0, 1, 0, 1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("contend_gnt0_c%0d", i), {31'd0, bus.m0_gnt}, (pat[i] == 0) ? 32'd1 : 32'd0);
      chk($sformatf("contend_gnt1_c%0d", i), {31'd0, bus.m1_gnt}, (pat[i] == 1) ? 32'd1 : 32'd0);
      next_cycle();
    end

    // lone m0 read moves owner to m1, then reset lands in the rvalid cycle
    idle_both();
    set_m(0, 1'b1, 1'b0, 1'b0, 9'h010, 2'b11, 16'h0000);
    next_cycle();
    idle_both();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_rvalid0", {31'd0, bus.m0_rvalid}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    set_m(0, 1'b1, 1'b0, 1'b0, 9'h003, 2'b11, 16'h0000);
    set_m(1, 1'b1, 1'b0, 1'b0, 9'h004, 2'b11, 16'h0000);
    @(negedge clk);
    chk("post_rst_m0_gnt", {31'd0, bus.m0_gnt}, 32'd1);
    chk("post_rst_m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
    chk("post_rst_rvalid0", {31'd0, bus.m0_rvalid}, 32'd0);
    chk("post_rst_rvalid1", {31'd0, bus.m1_rvalid}, 32'd0);

    // randomised traffic with occasional reset pulses
    for (int c = 0; c < 600; c++) begin
      next_cycle();
      rst_n = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      for (int n = 0; n < 2; n++)
        set_m(n, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
              9'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 16'($urandom));
    end
    next_cycle();
    rst_n = 1'b1;
    idle_both();
    repeat (3) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpram_port_arb.md
DPRAM_PORT_ARB -- requirements
Module: dpram_port_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, RAM word address width.
REQ-002 SHALL have parameter DATA_W, default 16, RAM data width.
REQ-003 SHALL have parameter SEL_W, default 2, byte-lane select width (DATA_W/8).
REQ-004 SHALL have parameter MAX_HOLD, default 4, maximum consecutive locked grants to one requester (range 1..15).
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock for all state and the RAM port; rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL provide, for each requester N in {0,1}, these ports:
- mN_req input 1, access request.
- mN_lock input 1, request to keep ownership next cycle.
- mN_we input 1, write when 1, read when 0.
- mN_addr input ADDR_W, word address.
- mN_sel input SEL_W, byte-lane enables.
- mN_wdata input DATA_W, write data.
- mN_gnt output 1, access issued this cycle.
- mN_rvalid output 1, read data valid.
- mN_rdata output DATA_W, read data.
REQ-007 SHALL drive one RAM port with: ram_addr output ADDR_W; ram_sel output SEL_W; ram_we output 1; ram_ce output 1; ram_write output DATA_W; ram_read input DATA_W (synchronous read, 1-cycle latency).

Function
REQ-008 SHALL issue at most one RAM access per cycle: ram_ce=1 iff at least one mN_req=1 and rst_n=1.
REQ-009 SHALL assert mN_gnt combinationally in the same cycle its access is driven onto ram_*; the two grants SHALL never be 1 together.
REQ-010 SHALL mux the granted requester's addr/sel/we/wdata onto ram_addr/ram_sel/ram_we/ram_write; when idle, ram_we=0 and ram_sel=0.
REQ-011 SHALL keep an owner state with two states, OWN0 and OWN1; the owner wins when both requesters request.
REQ-012 SHALL transition the owner after each granted cycle as follows:
- If the granted requester has lock=1 and hold<MAX_HOLD, the owner stays and hold increments.
- Otherwise the owner moves to the other requester and hold clears.
REQ-013 SHALL pass the owner to the other requester once hold reaches MAX_HOLD, even if lock remains high; hold then clears.
REQ-014 SHALL grant a single requester immediately regardless of owner; the owner state then follows REQ-012/013 for that requester.
REQ-015 SHALL assert mN_rvalid exactly one cycle after a granted read (mN_we=0) by N; writes SHALL produce no rvalid.
REQ-016 SHALL drive mN_rdata=ram_read; the value is meaningful only while mN_rvalid=1.
REQ-017 SHALL ignore mN_wdata and mN_sel for reads apart from passing them through; byte masking is performed by the RAM.
REQ-018 SHALL leave holding req stable until gnt to the requester; a request withdrawn before grant is dropped without error.

Reset
REQ-019 SHALL, while rst_n=0, force:
- owner=OWN0 and hold=0;
- m0_rvalid=m1_rvalid=0;
- m0_gnt=m1_gnt=0;
- ram_ce=0 and ram_we=0.
REQ-020 SHALL, when reset is asserted mid-read, suppress the pending rvalid; there SHALL be no rvalid in the cycle after rst_n deasserts.

Configuration
REQ-021 SHALL, with macro DPRAM_PORT_ARB_LOCK_EN defined, implement lock/hold per REQ-012/013.
REQ-022 SHALL, without DPRAM_PORT_ARB_LOCK_EN, ignore mN_lock and omit the hold counter; the owner then always alternates after every contended grant (pure round-robin).

Structure
REQ-023 SHALL place the default widths, MAX_HOLD, the owner-state encoding (OWN0=0, OWN1=1) and the hold counter width (4 bits) in the shared package dpram_pkg.
REQ-024 SHALL implement the owner/hold logic as one sub-module, dpram_rr_sched; the muxing and rvalid pipeline stay in dpram_port_arb.

Verification
REQ-025 SHALL verify that after reset, m1_req=1 alone writing addr 0x010, sel 2'b11, data 0xBEEF gives m1_gnt=1 in the same cycle, ram_we=1, and no rvalid.
REQ-026 SHALL verify that with both requesters reading after reset (m0 addr 0x010, m1 addr 0x011), m0 is granted first and m1 next; m0_rvalid returns 0xBEEF one cycle after m0_gnt.
REQ-027 SHALL verify that with LOCK_EN and MAX_HOLD=4, m0 holding lock=1 and both requesting gives m0 grants in 4 consecutive cycles, then an m1 grant in cycle 5.
REQ-028 SHALL verify that without LOCK_EN, continuous contention alternates m0,m1,m0,m1 regardless of lock.
REQ-029 SHALL verify that a byte write with sel=2'b01, data 0x1234 to addr 0x010 holding 0xBEEF reads back 0xBE34.
REQ-030 SHALL verify that with rst_n pulsed low in the cycle after a granted read, no rvalid is seen and the owner returns to OWN0.
